// File: rtl/ws2812b_strip_ctrl_if.sv
// ----------------------------------------------------------------------------
// ws2812b_strip_ctrl_if
// Pixel stream between the frame sequencer and the WS2812B bit serializer.
//   px_data  : pixel colour, wire order GRB, MSB first
//   px_valid : pixel valid, held until accepted
//   px_latch : marks the last pixel of a frame
//   px_ready : serializer ready to accept a pixel
// master = frame sequencer (source), slave = serializer (sink).
// ----------------------------------------------------------------------------
interface ws2812b_strip_ctrl_if;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_latch;
  logic        px_ready;

  modport master (
    output px_data,
    output px_valid,
    output px_latch,
    input  px_ready
  );

  modport slave (
    input  px_data,
    input  px_valid,
    input  px_latch,
    output px_ready
  );
endinterface

// File: rtl/ws2812b_strip_ctrl.sv
// ----------------------------------------------------------------------------
// ws2812b_strip_ctrl
// Frame sequencer for the WS2812B serializer. Holds a host-written pixel
// buffer and, on start, streams the first min(len, NUM_PIXELS) pixels to the
// serializer, flagging the last one with px_latch.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_wr_en      : buffer write strobe
//   i_wr_addr    : buffer write index (writes >= NUM_PIXELS ignored)
//   i_wr_data    : pixel colour (GRB)
//   i_start      : single-cycle frame start (ignored while busy)
//   i_fill       : with start, send pixel 0 to every position
//   i_len        : with start, number of pixels to send
//   i_bright     : global brightness (only with WS2812B_BRIGHTNESS_EN)
//   o_busy       : frame in progress
//   o_done       : one-cycle pulse at frame completion
//   px           : pixel stream to serializer (master modport)
//
// Build option: define WS2812B_BRIGHTNESS_EN to scale each channel by
// (bright+1)/256 when the pixel is loaded.
// ----------------------------------------------------------------------------
module ws2812b_strip_ctrl #(
  parameter int unsigned NUM_PIXELS = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [IDX_W-1:0]    i_wr_addr,
  input  logic [23:0]         i_wr_data,
  input  logic                i_start,
  input  logic                i_fill,
  input  logic [IDX_W:0]      i_len,
  input  logic [7:0]          i_bright,
  output logic                o_busy,
  output logic                o_done,
  ws2812b_strip_ctrl_if.master px
);

  localparam int unsigned  CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] NP_L = CNT_W'(NUM_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t           r_state, w_state;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_px_valid, w_px_valid;
  logic             r_px_latch, w_px_latch;
  logic [23:0]      r_px_data, w_px_data;
  logic [CNT_W-1:0] r_index, w_index;
  logic [CNT_W-1:0] r_eff_len, w_eff_len;
  logic             r_fill, w_fill;

  logic [23:0]      r_buf [NUM_PIXELS];
  logic [IDX_W-1:0] w_rd_addr;
  logic [23:0]      w_buf_px;
  logic [23:0]      w_load_px;
  logic [CNT_W-1:0] w_len_clip;

  // Pixel buffer: no reset, written in any state
  always_ff @(posedge clk) begin
    if (i_wr_en && (CNT_W'(i_wr_addr) < NP_L)) begin
      r_buf[i_wr_addr] <= i_wr_data;
    end
  end

  assign w_rd_addr  = r_fill ? '0 : r_index[IDX_W-1:0];
  assign w_buf_px   = r_buf[w_rd_addr];
  assign w_len_clip = (i_len > NP_L) ? NP_L : i_len;

`ifdef WS2812B_BRIGHTNESS_EN
  // Channel scale: (c * (bright+1)) >> 8, so 255 is identity and 0 blanks
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * (16'(b) + 16'd1);
    return prod[15:8];
  endfunction

  assign w_load_px = {scale_ch(w_buf_px[23:16], i_bright),
                      scale_ch(w_buf_px[15:8],  i_bright),
                      scale_ch(w_buf_px[7:0],   i_bright)};
`else
  logic w_unused_bright;
  assign w_unused_bright = ^i_bright;
  assign w_load_px       = w_buf_px;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_px_valid <= 1'b0;
      r_px_latch <= 1'b0;
      r_px_data  <= '0;
      r_index    <= '0;
      r_eff_len  <= '0;
      r_fill     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_px_valid <= w_px_valid;
      r_px_latch <= w_px_latch;
      r_px_data  <= w_px_data;
      r_index    <= w_index;
      r_eff_len  <= w_eff_len;
      r_fill     <= w_fill;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state    = r_state;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_px_valid = r_px_valid;
    w_px_latch = r_px_latch;
    w_px_data  = r_px_data;
    w_index    = r_index;
    w_eff_len  = r_eff_len;
    w_fill     = r_fill;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_fill    = i_fill;
          w_eff_len = w_len_clip;
          w_index   = '0;
          if (w_len_clip == '0) begin
            w_state = S_FIN;
          end else begin
            w_busy  = 1'b1;
            w_state = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        w_px_data  = w_load_px;
        w_px_latch = (r_index == (r_eff_len - CNT_W'(1)));
        w_px_valid = 1'b1;
        w_state    = S_SEND;
      end

      S_SEND: begin
        if (px.px_ready && r_px_valid) begin
          w_px_valid = 1'b0;
          if (r_px_latch) begin
            w_state = S_DRAIN;
          end else begin
            w_index = r_index + CNT_W'(1);
            w_state = S_LOAD;
          end
        end
      end

      // Serializer drops ready after the last handshake; its return means
      // the bits and the latch gap have gone out
      S_DRAIN: begin
        if (px.px_ready) begin
          w_state = S_FIN;
        end
      end

      S_FIN: begin
        w_done     = 1'b1;
        w_busy     = 1'b0;
        w_px_latch = 1'b0;
        w_state    = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign px.px_data  = r_px_data;
  assign px.px_valid = r_px_valid;
  assign px.px_latch = r_px_latch;

endmodule

// File: tb/tb_ws2812b_strip_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ws2812b_strip_ctrl
// Directed and randomized frames against a buffer-level reference model.
// Inputs change 1 time unit after the rising edge; the serializer ready model
// updates 2 units after; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_ws2812b_strip_ctrl;

  localparam int NP    = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [23:0]      wr_data;
  logic             start;
  logic             fill;
  logic [IDX_W:0]   len;
  logic [7:0]       bright;
  logic             busy;
  logic             done;

  ws2812b_strip_ctrl_if px_if ();

  ws2812b_strip_ctrl #(.NUM_PIXELS(NP), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_start   (start),
    .i_fill    (fill),
    .i_len     (len),
    .i_bright  (bright),
    .o_busy    (busy),
    .o_done    (done),
    .px        (px_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] model_buf [NP];
  logic [23:0] cap_d [$];
  bit          cap_l [$];
  int          done_cnt = 0;
  int          exp_n;
  bit          exp_fill;
  int          d0;

  // Serializer ready model controls
  bit rdy_hold = 1'b0;
  int rdy_gap  = 5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_px(input logic [23:0] p);
`ifdef WS2812B_BRIGHTNESS_EN
    int b;
    b = int'(bright) + 1;
    return {8'((int'(p[23:16]) * b) / 256),
            8'((int'(p[15:8])  * b) / 256),
            8'((int'(p[7:0])   * b) / 256)};
`else
    return p;
`endif
  endfunction

  // Serializer model: ready drops after each accepted pixel, returns rdy_gap later
  initial begin
    int  cnt;
    bit  hs;
    cnt = 0;
    px_if.px_ready = 1'b1;
    forever begin
      @(negedge clk);
      hs = px_if.px_valid && px_if.px_ready;
      @(posedge clk);
      #2;
      if (rdy_hold) begin
        px_if.px_ready = 1'b0;
        cnt = 0;
      end else if (hs && rst_n) begin
        px_if.px_ready = 1'b0;
        cnt = rdy_gap;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) px_if.px_ready = 1'b1;
      end else begin
        px_if.px_ready = 1'b1;
      end
    end
  end

  // Handshake and done monitor
  initial begin
    forever begin
      @(negedge clk);
      if (px_if.px_valid && px_if.px_ready && rst_n) begin
        cap_d.push_back(px_if.px_data);
        cap_l.push_back(px_if.px_latch);
      end
      if (done) done_cnt++;
    end
  end

  task automatic write_px(input int addr, input logic [23:0] data);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_data = data;
    model_buf[addr] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic start_frame(input int l, input bit f);
    exp_n    = (l > NP) ? NP : l;
    exp_fill = f;
    cap_d.delete();
    cap_l.delete();
    d0    = done_cnt;
    start = 1'b1;
    len   = (IDX_W+1)'(l);
    fill  = f;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Start-relative timing: busy at start+1, first px_valid (or done) at start+2
  task automatic timing_chk();
    @(negedge clk);
    chk("busy_start1", 32'(busy), 32'(exp_n > 0));
    chk("done_start1", 32'(done), 0);
    chk("valid_start1", 32'(px_if.px_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("valid_start2", 32'(px_if.px_valid), 32'(exp_n > 0));
    chk("done_start2", 32'(done), 32'(exp_n == 0));
  endtask

  task automatic finish_frame();
    int c;
    logic [23:0] e;
    c = 0;
    while (done_cnt == d0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("done_count", 32'(done_cnt - d0), 1);
    chk("busy_after", 32'(busy), 0);
    chk("hs_count", 32'(cap_d.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < cap_d.size(); i++) begin
      e = exp_px(model_buf[exp_fill ? 0 : i]);
      chk($sformatf("px_data[%0d]", i), 32'(cap_d[i]), 32'(e));
      chk($sformatf("px_latch[%0d]", i), 32'(cap_l[i]), 32'(i == exp_n - 1));
    end
  endtask

  task automatic run_frame(input int l, input bit f);
    start_frame(l, f);
    finish_frame();
  endtask

  initial begin
    logic [23:0] d_hold;
    int          bad;
    int          dsave;
    bit          found;

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    fill    = 1'b0;
    len     = '0;
    bright  = 8'd255;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_valid", 32'(px_if.px_valid), 0);
    chk("rst_latch", 32'(px_if.px_latch), 0);
    chk("rst_data",  32'(px_if.px_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic three-pixel frame
    write_px(0, 24'hFF0000);
    write_px(1, 24'h00FF00);
    write_px(2, 24'h0000FF);
    start_frame(3, 1'b0);
    timing_chk();
    finish_frame();
    if (cap_d.size() == 3)
      chk("basic_px2", 32'(cap_d[2]), 32'h0000FF);

    // Serializer stalls with ready low during SEND
    rdy_hold = 1'b1;
    @(posedge clk); #1;
    start_frame(2, 1'b0);
    @(posedge clk); #1;
    chk("stall_valid", 32'(px_if.px_valid), 1);
    d_hold = px_if.px_data;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(px_if.px_valid === 1'b1 && px_if.px_data === d_hold)) bad++;
    end
    @(posedge clk); #1;
    chk("stall_stable", 32'(bad), 0);
    chk("stall_no_hs", 32'(cap_d.size()), 0);
    rdy_hold = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stall_one_hs", 32'(cap_d.size()), 1);
    finish_frame();

    // Fill mode
    write_px(0, 24'h123456);
    run_frame(4, 1'b1);

    // Zero length: done two cycles after start, no pixels
    start_frame(0, 1'b0);
    timing_chk();
    finish_frame();

    // Over-long request clips to buffer depth
    for (int i = 0; i < NP; i++) write_px(i, 24'($urandom));
    run_frame(NP + 3, 1'b0);

    // Start while busy is ignored
    rdy_gap = 3;
    start_frame(3, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("inject_busy", 32'(busy), 1);
    start = 1'b1;
    len   = (IDX_W+1)'(7);
    fill  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_frame();
    repeat (10) @(posedge clk);
    #1;
    chk("inject_no_extra_hs", 32'(cap_d.size()), 3);
    chk("inject_no_extra_done", 32'(done_cnt - d0), 1);

    // Asynchronous reset during SEND of pixel 2
    start_frame(5, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(posedge clk); #1;
      if (cap_d.size() == 1 && px_if.px_valid === 1'b1) found = 1'b1;
    end
    chk("rst_reach_px2", 32'(found), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(px_if.px_valid), 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_done",  32'(done), 0);
    chk("arst_latch", 32'(px_if.px_latch), 0);
    dsave = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("arst_no_done", 32'(done_cnt - dsave), 0);
    run_frame(1, 1'b0);

`ifdef WS2812B_BRIGHTNESS_EN
    write_px(0, 24'hFF8040);
    bright = 8'd127;
    run_frame(1, 1'b0);
    if (cap_d.size() == 1) chk("bright127", 32'(cap_d[0]), 32'h7F4020);
    bright = 8'd255;
    run_frame(1, 1'b0);
    if (cap_d.size() == 1) chk("bright255", 32'(cap_d[0]), 32'hFF8040);
`endif

    // Randomized frames
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NP; i++) write_px(i, 24'($urandom));
      rdy_gap = int'($urandom_range(1, 6));
      bright  = 8'($urandom);
      run_frame(int'($urandom_range(0, NP + 4)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
